fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops burst_len beats from a synchronous-read FIFO into a
// 2-entry skid buffer feeding a valid/ready stream. Optional xfer_cnt port: FIFO_RD_CNT_EN.
module fifo_rd_ctrl #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [CW-1:0] burst_len,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          busy,
    output logic          done
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CW-1:0] xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] w_issued_inc;
    logic          r_inflight;
    logic [DW-1:0] r_buf [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_count;
    logic [1:0]    w_count_nxt;
    logic [1:0]    w_pending;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_push       = r_inflight;
    assign w_pop        = m_valid && m_ready;
    assign w_issued_inc = r_issued + CW'(1);
    assign w_count_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Credit check counts the slot freed by this cycle's transfer, which is what
    // lets a full-rate stream keep one read in flight and one beat buffered.
    assign w_pending  = {1'b0, r_inflight} + r_count - {1'b0, w_pop};
    assign fifo_rd_en = (r_state == ST_READ) && !fifo_empty &&
                        (r_issued < r_len) && (w_pending < 2'd2);

    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_buf[r_rd_ptr];
    assign busy    = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done    = (r_state == ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (burst_len != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (fifo_rd_en && (w_issued_inc == r_len)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_inflight && (w_count_nxt == 2'd0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            // NOTE: the skid entries are reset because m_data must read zero in reset.
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_en;
            if (w_accept) begin
                r_len    <= burst_len;
                r_issued <= '0;
            end else if (fifo_rd_en) begin
                r_issued <= w_issued_inc;
            end
            if (w_push) begin
                r_buf[r_wr_ptr] <= fifo_rdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xfer_cnt <= '0;
        end else if (w_accept) begin
            xfer_cnt <= '0;
        end else if (w_pop) begin
            xfer_cnt <= xfer_cnt + CW'(1);
        end
    end
`endif

endmodule
